// File: rtl/jstk_spi_responder.sv
// -----------------------------------------------------------------------------
// jstk_spi_responder
//
// SPI slave (mode 0, MSB first) that emulates a joystick module. When the
// master selects the device, the block captures the joystick position and
// button state. It then streams that 5-byte frame out on miso. While the first
// byte shifts out, the block receives a command byte on mosi.
//
// Frame layout (byte order on the wire):
//   x_pos[7:0], {6'b0, x_pos[9:8]}, y_pos[7:0], {6'b0, y_pos[9:8]},
//   {5'b0, buttons}
// Any bits clocked after the 40th read as 0.
//
// Ports:
//   board_clk   system clock, all logic on its rising edge
//   reset       synchronous, active-high reset
//   ss          SPI slave select (active low, asynchronous)
//   sclk        SPI clock (asynchronous, period >= 8 board_clk cycles)
//   mosi        SPI data from master (asynchronous)
//   miso        SPI data to master
//   x_pos       10-bit joystick X value
//   y_pos       10-bit joystick Y value
//   buttons     {btn2, btn1, stick}
//   leds        LED bits taken from an accepted command byte
//   frame_done  one-cycle pulse: frame ended after a whole number (>= 5) of bytes
//   frame_err   one-cycle pulse: frame ended short or mid-byte
//   busy        high while the frame is active
//
// Build option:
//   JSTK_RESP_LED_EN  When this macro is defined, a command byte of the form
//                     6'b100000_xx loads leds on the 8th sclk rise. When the
//                     macro is not defined, leds is tied to 2'b00 and the block
//                     has no command register.
// -----------------------------------------------------------------------------
module jstk_spi_responder (
  input  logic       board_clk,
  input  logic       reset,
  input  logic       ss,
  input  logic       sclk,
  input  logic       mosi,
  output logic       miso,
  input  logic [9:0] x_pos,
  input  logic [9:0] y_pos,
  input  logic [2:0] buttons,
  output logic [1:0] leds,
  output logic       frame_done,
  output logic       frame_err,
  output logic       busy
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_END    = 2'd2
  } state_t;

  state_t      state_reg;

  // Synchronizers: *_meta_reg is the first flop and *_sync_reg is the second.
  logic        ss_meta_reg;
  logic        ss_sync_reg;
  logic        sclk_meta_reg;
  logic        sclk_sync_reg;
  logic        sclk_prev_reg;

  // sync_valid_reg fills with ones after reset. Once sync_valid_reg[1] is set,
  // ss_sync_reg holds a real sample of ss rather than its reset value.
  logic [1:0]  sync_valid_reg;

  // armed_reg is set only after ss has really been observed high. This stops a
  // master that is still holding ss low after a reset from being treated as a
  // fresh frame start.
  logic        armed_reg;

  logic [39:0] snapshot_reg;
  logic [2:0]  bit_cnt_reg;
  logic [2:0]  byte_cnt_reg;

  logic        sclk_rise;
  logic        sclk_fall;
  logic        ss_fall_ok;
  logic        ss_rise;
  logic [39:0] snap_load;

  // ---------------------------------------------------------------------------
  // Input synchronizers
  // ---------------------------------------------------------------------------
  always_ff @(posedge board_clk) begin
    if (reset) begin
      ss_meta_reg    <= 1'b1;
      ss_sync_reg    <= 1'b1;
      sclk_meta_reg  <= 1'b0;
      sclk_sync_reg  <= 1'b0;
      sclk_prev_reg  <= 1'b0;
      sync_valid_reg <= 2'b00;
    end else begin
      ss_meta_reg    <= ss;
      ss_sync_reg    <= ss_meta_reg;
      sclk_meta_reg  <= sclk;
      sclk_sync_reg  <= sclk_meta_reg;
      sclk_prev_reg  <= sclk_sync_reg;
      sync_valid_reg <= {sync_valid_reg[0], 1'b1};
    end
  end

  assign sclk_rise = sclk_sync_reg & ~sclk_prev_reg;
  assign sclk_fall = ~sclk_sync_reg & sclk_prev_reg;

  // A frame start needs the synchronized ss to be low and the first flop to
  // still be low. A low pulse on ss that is seen in only one sample therefore
  // dies in the synchronizer. The block stays idle and raises no pulse.
  assign ss_fall_ok = armed_reg & ~ss_sync_reg & ~ss_meta_reg;
  assign ss_rise    = ss_sync_reg;

  assign snap_load = {x_pos[7:0], 6'b0, x_pos[9:8],
                      y_pos[7:0], 6'b0, y_pos[9:8],
                      5'b0, buttons};

  // ---------------------------------------------------------------------------
  // Optional command capture (LED bits)
  // ---------------------------------------------------------------------------
`ifdef JSTK_RESP_LED_EN
  logic       mosi_meta_reg;
  logic       mosi_sync_reg;
  logic [6:0] cmd_shift_reg;
  logic [1:0] leds_reg;
  logic [7:0] cmd_byte;

  // mosi goes through the same two-flop depth as sclk. The data bit therefore
  // lines up with the detected sclk rise.
  always_ff @(posedge board_clk) begin
    if (reset) begin
      mosi_meta_reg <= 1'b0;
      mosi_sync_reg <= 1'b0;
    end else begin
      mosi_meta_reg <= mosi;
      mosi_sync_reg <= mosi_meta_reg;
    end
  end

  assign cmd_byte = {cmd_shift_reg, mosi_sync_reg};

  always_ff @(posedge board_clk) begin
    if (reset) begin
      cmd_shift_reg <= 7'd0;
      leds_reg      <= 2'b00;
    end else if (state_reg == ST_ACTIVE && !ss_rise && sclk_rise) begin
      cmd_shift_reg <= cmd_byte[6:0];
      // Only the first byte of a frame is a command. That byte completes on
      // the 8th rise, when byte_cnt is 0 and bit_cnt is 7.
      if (byte_cnt_reg == 3'd0 && bit_cnt_reg == 3'd7 &&
          cmd_byte[7:2] == 6'b100000) begin
        leds_reg <= cmd_byte[1:0];
      end
    end
  end

  assign leds = leds_reg;
`else
  logic unused_mosi;
  assign unused_mosi = mosi;
  assign leds        = 2'b00;
`endif

  // ---------------------------------------------------------------------------
  // Frame FSM. All outputs are registered.
  // ---------------------------------------------------------------------------
  always_ff @(posedge board_clk) begin
    if (reset) begin
      state_reg    <= ST_IDLE;
      armed_reg    <= 1'b0;
      snapshot_reg <= 40'd0;
      bit_cnt_reg  <= 3'd0;
      byte_cnt_reg <= 3'd0;
      miso         <= 1'b0;
      busy         <= 1'b0;
      frame_done   <= 1'b0;
      frame_err    <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      if (sync_valid_reg[1] && ss_sync_reg) begin
        armed_reg <= 1'b1;
      end

      case (state_reg)
        ST_IDLE: begin
          miso <= 1'b0;
          busy <= 1'b0;
          if (ss_fall_ok) begin
            state_reg    <= ST_ACTIVE;
            busy         <= 1'b1;
            armed_reg    <= 1'b0;
            snapshot_reg <= snap_load;
            // The first bit must be on the line before the first sclk rise.
            miso         <= snap_load[39];
            bit_cnt_reg  <= 3'd0;
            byte_cnt_reg <= 3'd0;
          end
        end

        ST_ACTIVE: begin
          if (ss_rise) begin
            state_reg <= ST_END;
            busy      <= 1'b0;
            miso      <= 1'b0;
            // The pulse is registered, so it is high during the END cycle.
            if (byte_cnt_reg >= 3'd5 && bit_cnt_reg == 3'd0) begin
              frame_done <= 1'b1;
            end else begin
              frame_err <= 1'b1;
            end
          end else begin
            if (sclk_rise) begin
              bit_cnt_reg <= bit_cnt_reg + 3'd1;
              if (bit_cnt_reg == 3'd7 && byte_cnt_reg != 3'd5) begin
                byte_cnt_reg <= byte_cnt_reg + 3'd1;
              end
            end
            // Zeros shift in from the bottom. Once 40 bits have gone out,
            // miso reads 0 without any extra bookkeeping.
            if (sclk_fall) begin
              snapshot_reg <= {snapshot_reg[38:0], 1'b0};
              miso         <= snapshot_reg[38];
            end
          end
        end

        ST_END: begin
          state_reg <= ST_IDLE;
          miso      <= 1'b0;
          busy      <= 1'b0;
        end

        default: begin
          state_reg <= ST_IDLE;
          miso      <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_jstk_spi_responder.sv
// -----------------------------------------------------------------------------
// tb_jstk_spi_responder
//
// Testbench for jstk_spi_responder. The bench acts as an SPI master and runs
// directed frames followed by randomized frames. The expected data bytes come
// from the joystick values using plain arithmetic:
//   byte0 = x % 256, byte1 = x / 256, byte2 = y % 256, byte3 = y / 256,
//   byte4 = buttons, and every later byte = 0.
// The expected frame outcome comes from the number of bits clocked.
// The expected LED value comes from the command byte and the build option.
// -----------------------------------------------------------------------------
module tb_jstk_spi_responder;

  logic       board_clk = 1'b0;
  logic       reset;
  logic       ss;
  logic       sclk;
  logic       mosi;
  logic       miso;
  logic [9:0] x_pos;
  logic [9:0] y_pos;
  logic [2:0] buttons;
  logic [1:0] leds;
  logic       frame_done;
  logic       frame_err;
  logic       busy;

`ifdef JSTK_RESP_LED_EN
  localparam bit LED_EN = 1'b1;
`else
  localparam bit LED_EN = 1'b0;
`endif

  jstk_spi_responder dut (
    .board_clk  (board_clk),
    .reset      (reset),
    .ss         (ss),
    .sclk       (sclk),
    .mosi       (mosi),
    .miso       (miso),
    .x_pos      (x_pos),
    .y_pos      (y_pos),
    .buttons    (buttons),
    .leds       (leds),
    .frame_done (frame_done),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  always #5 board_clk = ~board_clk;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int both_cnt = 0;

  logic [7:0] rx_bytes [0:5];
  logic [1:0] led_model;

  // Pulse monitor. It counts every frame_done and frame_err pulse, and every
  // cycle in which both are high.
  always @(negedge board_clk) begin
    if (frame_done) done_cnt++;
    if (frame_err) err_cnt++;
    if (frame_done && frame_err) both_cnt++;
  end

  task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(posedge board_clk);
    #1;
  endtask

  // One SPI transaction of nbits bits. The first 8 mosi bits carry cmd, MSB
  // first. At bit index chg_bit, x_pos switches to chg_x. At bit index
  // rst_bit, reset is pulsed for one cycle. Pass -1 to disable either action.
  task automatic spi_xfer(input int nbits, input logic [7:0] cmd, input int chg_bit,
                          input logic [9:0] chg_x, input int rst_bit);
    for (int b = 0; b < 6; b++) rx_bytes[b] = 8'h00;
    ss = 1'b0;
    wait_clks(8);
    if (rst_bit < 0) check("busy_in_frame", 48'(busy), 48'd1);
    for (int i = 0; i < nbits; i++) begin
      if (i == chg_bit) x_pos = chg_x;
      if (i == rst_bit) begin
        reset = 1'b1;
        wait_clks(1);
        reset = 1'b0;
        wait_clks(1);
        check("rst_busy", 48'(busy), 48'd0);
        check("rst_miso", 48'(miso), 48'd0);
      end
      if (i < 8) mosi = cmd[7 - i];
      else mosi = 1'($urandom_range(0, 1));
      wait_clks(8);
      rx_bytes[i / 8][7 - (i % 8)] = miso;
      sclk = 1'b1;
      wait_clks(8);
      sclk = 1'b0;
    end
    wait_clks(8);
    ss   = 1'b1;
    mosi = 1'b0;
    wait_clks(10);
  endtask

  // Runs one frame and checks it against the reference model.
  task automatic run_frame(input string name, input int nbits, input logic [7:0] cmd,
                           input int chg_bit, input logic [9:0] chg_x, input int rst_bit);
    int  exp_b [0:5];
    int  d0, e0, nfull;
    bit  exp_done;
    exp_b[0] = int'(x_pos) % 256;
    exp_b[1] = int'(x_pos) / 256;
    exp_b[2] = int'(y_pos) % 256;
    exp_b[3] = int'(y_pos) / 256;
    exp_b[4] = int'(buttons);
    exp_b[5] = 0;
    d0 = done_cnt;
    e0 = err_cnt;
    spi_xfer(nbits, cmd, chg_bit, chg_x, rst_bit);
    nfull = nbits / 8;
    if (rst_bit >= 0) nfull = rst_bit / 8;
    for (int j = 0; j < nfull; j++) begin
      check($sformatf("%s_byte%0d", name, j), 48'(rx_bytes[j]), 48'(exp_b[j]));
    end
    if (rst_bit >= 0) begin
      led_model = 2'b00;
      check({name, "_done_cnt"}, 48'(done_cnt - d0), 48'd0);
      check({name, "_err_cnt"}, 48'(err_cnt - e0), 48'd0);
    end else begin
      exp_done = (nbits >= 40) && (nbits % 8 == 0);
      check({name, "_done_cnt"}, 48'(done_cnt - d0), exp_done ? 48'd1 : 48'd0);
      check({name, "_err_cnt"}, 48'(err_cnt - e0), exp_done ? 48'd0 : 48'd1);
      if (LED_EN && nbits >= 8 && (int'(cmd) / 4) == 32) led_model = cmd[1:0];
    end
    check({name, "_leds"}, 48'(leds), 48'(led_model));
    check({name, "_busy_after"}, 48'(busy), 48'd0);
    check({name, "_miso_after"}, 48'(miso), 48'd0);
    $display("frame %s bits=%0d cmd=%02h x=%03h y=%03h btn=%0d leds=%0d", name, nbits, cmd,
             x_pos, y_pos, buttons, leds);
  endtask

  initial begin
    int d0, e0;
    int len_tab [0:7];
    logic [7:0] rcmd;
    len_tab = '{40, 48, 13, 39, 41, 8, 32, 40};

    reset     = 1'b1;
    ss        = 1'b1;
    sclk      = 1'b0;
    mosi      = 1'b0;
    x_pos     = 10'd0;
    y_pos     = 10'd0;
    buttons   = 3'd0;
    led_model = 2'b00;
    wait_clks(3);
    reset = 1'b0;
    wait_clks(1);
    check("rst_miso", 48'(miso), 48'd0);
    check("rst_busy", 48'(busy), 48'd0);
    check("rst_leds", 48'(leds), 48'd0);
    check("rst_frame_done", 48'(frame_done), 48'd0);
    check("rst_frame_err", 48'(frame_err), 48'd0);
    wait_clks(4);

    // Reference frame: expected bytes are A5 02 3C 01 05.
    x_pos = 10'h2A5; y_pos = 10'h13C; buttons = 3'b101;
    run_frame("ref", 40, 8'h83, -1, 10'h000, -1);
    check("ref_lit_b0", 48'(rx_bytes[0]), 48'hA5);
    check("ref_lit_b4", 48'(rx_bytes[4]), 48'h05);

    // x_pos changes partway through the frame, then the next frame picks it up.
    run_frame("midchg", 40, 8'h80, 24, 10'h000, -1);
    run_frame("after_chg", 40, 8'h81, -1, 10'h000, -1);

    // Short frame, 6-byte frame, and a command the block must reject.
    run_frame("short13", 13, 8'h82, -1, 10'h000, -1);
    run_frame("six_byte", 48, 8'h83, -1, 10'h000, -1);
    run_frame("bad_cmd", 40, 8'h43, -1, 10'h000, -1);

    // Drop ss for a single sample. The block must stay idle.
    d0 = done_cnt; e0 = err_cnt;
    ss = 1'b0; wait_clks(1); ss = 1'b1; wait_clks(10);
    check("glitch_busy", 48'(busy), 48'd0);
    check("glitch_pulses", 48'((done_cnt - d0) + (err_cnt - e0)), 48'd0);
    $display("glitch on ss: busy=%0d", busy);

    // Toggle sclk while ss is high. The block must ignore it.
    d0 = done_cnt; e0 = err_cnt;
    for (int k = 0; k < 4; k++) begin
      sclk = 1'b1; wait_clks(8); sclk = 1'b0; wait_clks(8);
    end
    wait_clks(10);
    check("sclk_idle_pulses", 48'((done_cnt - d0) + (err_cnt - e0)), 48'd0);
    check("sclk_idle_miso", 48'(miso), 48'd0);
    $display("sclk while deselected: miso=%0d", miso);

    // Reset in the second byte, then a clean frame.
    x_pos = 10'h2A5;
    run_frame("rst_mid", 40, 8'h83, -1, 10'h000, 12);
    run_frame("post_rst", 40, 8'h81, -1, 10'h000, -1);

    // Randomized frames.
    for (int r = 0; r < 10; r++) begin
      x_pos   = 10'($urandom_range(0, 1023));
      y_pos   = 10'($urandom_range(0, 1023));
      buttons = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 1) == 1) rcmd = 8'h80 | 8'($urandom_range(0, 3));
      else rcmd = 8'($urandom_range(0, 255));
      run_frame($sformatf("rand%0d", r), len_tab[$urandom_range(0, 7)], rcmd, -1, 10'h000, -1);
    end

    check("never_both_pulses", 48'(both_cnt), 48'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/jstk_spi_responder.md
JSTK_SPI_RESPONDER -- requirements
Module: jstk_spi_responder

Interface
REQ-001 The block SHALL have these ports, each stated as name, direction, width and meaning:
- board_clk  in  1  system clock; all logic is on its rising edge
- reset  in  1  synchronous, active-high reset
- ss  in  1  SPI slave select from master, active low, asynchronous
- sclk  in  1  SPI serial clock from master, asynchronous
- mosi  in  1  SPI data from master, asynchronous
- miso  out  1  SPI data to master
- x_pos  in  10  joystick X value to report
- y_pos  in  10  joystick Y value to report
- buttons  in  3  button states {btn2, btn1, stick}
- leds  out  2  LED bits taken from the master command
- frame_done  out  1  one-cycle pulse when a complete 5-byte frame ends
- frame_err  out  1  one-cycle pulse when a frame ends short or misaligned
- busy  out  1  high while ss is asserted (synchronized)
REQ-002 Reset is reset, synchronous, active-high; the clock is board_clk.

Function
REQ-003 ss, sclk and mosi SHALL each pass through a 2-flop synchronizer; edges are detected on the synchronized values.
REQ-004 sclk period SHALL be at least 8 board_clk cycles; behaviour at faster sclk is undefined.
REQ-005 The SPI mode SHALL be mode 0, MSB first: mosi is sampled on a detected sclk rise; miso changes on a detected sclk fall.
REQ-006 The FSM SHALL have three states:
- IDLE -> ACTIVE on a synchronized ss fall
- ACTIVE -> END on a synchronized ss rise
- END -> IDLE after one cycle
REQ-007 On entry to ACTIVE, a 40-bit snapshot SHALL be loaded in this order: {x_pos[7:0], 6'b0, x_pos[9:8], y_pos[7:0], 6'b0, y_pos[9:8], 5'b0, buttons}. Inputs that change mid-frame SHALL NOT affect the frame.
REQ-008 miso SHALL present snapshot bit 39 in the same cycle as the ACTIVE entry, then advance one bit per sclk fall.
REQ-009 After 40 bits, miso SHALL be 0 for any further bits; extra bytes are ignored.
REQ-010 In IDLE, miso SHALL be 0.
REQ-011 A 3-bit bit counter and a 3-bit byte counter (saturating at 5) SHALL count sclk rises.
REQ-012 The byte-0 command SHALL be accepted on the 8th rise only if its bits [7:2] are 6'b100000.
REQ-013 In END, frame_done SHALL pulse if the byte count is at least 5 and the bit count is 0; otherwise frame_err SHALL pulse.
REQ-014 frame_done and frame_err SHALL never both be high in the same cycle.
REQ-015 If sclk edges arrive while ss is high, they SHALL be ignored.
REQ-016 If a ss fall and a ss rise occur within one synchronizer window, the block SHALL stay in IDLE with no pulse.
REQ-017 busy SHALL equal the state being ACTIVE.

Reset
REQ-018 reset SHALL set state=IDLE, miso=0, leds=2'b00, frame_done=0, frame_err=0, busy=0, counters=0, snapshot=0 and synchronizers=idle (ss=1, sclk=0).
REQ-019 A reset during ACTIVE SHALL abort the frame with no pulses, and the block SHALL wait for a fresh ss fall.

Configuration
REQ-020 The macro JSTK_RESP_LED_EN SHALL control LED capture:
- defined: an accepted command (REQ-012) loads leds with byte0[1:0] on the 8th sclk rise
- undefined: leds is constant 2'b00 and no command register exists

Verification
REQ-021 x_pos=10'h2A5, y_pos=10'h13C, buttons=3'b101, a 5-byte frame with command 0x83 -> master receives A5 02 3C 01 05; frame_done pulses once; leds=2'b11 (macro defined) or 2'b00 (undefined).
REQ-022 x_pos changes to 10'h000 after the 3rd byte of the frame -> bytes 4-5 are unchanged and the next frame reports 00 00.
REQ-023 ss rises after 13 bits -> frame_err pulses, frame_done stays 0, miso=0, busy=0.
REQ-024 A 6-byte frame -> the 6th byte reads 0x00 and frame_done pulses.
REQ-025 Command 0x43 -> leds hold their previous value; the frame data is still returned.
REQ-026 reset asserted for 1 cycle during byte 2 -> no pulse, all outputs at reset values; the next full frame is correct.
